// File: rtl/dram_ring_loopback_if.sv
// Bundles the PCIe slot DMA beat streams and the interleaved memory port
// of the DRAM ring loopback engine.
interface dram_ring_loopback_if #(
  parameter int DATA_W = 512
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [15:0]       in_slot;
  logic [3:0]        in_pad;
  logic              in_last;
  logic              in_full;
  logic              mreq_valid;
  logic              mreq_is_write;
  logic [63:0]       mreq_addr;
  logic [DATA_W-1:0] mreq_data;
  logic              mreq_grant;
  logic              mresp_valid;
  logic [DATA_W-1:0] mresp_data;
  logic              mresp_grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       out_slot;
  logic [3:0]        out_pad;
  logic              out_last;
  logic              out_grant;

  modport slave (
    input  in_valid, in_data, in_slot, in_pad, in_last,
    input  mreq_grant, mresp_valid, mresp_data, out_grant,
    output in_full, mreq_valid, mreq_is_write, mreq_addr, mreq_data,
    output mresp_grant, out_valid, out_data, out_slot, out_pad, out_last
  );

  modport master (
    output in_valid, in_data, in_slot, in_pad, in_last,
    output mreq_grant, mresp_valid, mresp_data, out_grant,
    input  in_full, mreq_valid, mreq_is_write, mreq_addr, mreq_data,
    input  mresp_grant, out_valid, out_data, out_slot, out_pad, out_last
  );
endinterface

// File: rtl/dram_ring_loopback.sv
// DRAM ring loopback engine: input beats are written into a circular DRAM
// region, completed jobs are read back in order and returned on PCIe.
module drl_fifo #(
  parameter int W     = 8,
  parameter int LOG_D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int D = 1 << LOG_D;
  localparam logic [LOG_D-1:0] PTR_ONE = 1;
  localparam logic [LOG_D:0]   CNT_ONE = 1;

  logic [W-1:0]     mem [D];
  logic [LOG_D-1:0] wr_ptr, rd_ptr;
  logic [LOG_D:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = count[LOG_D];
endmodule

module dram_ring_loopback #(
  parameter int          DATA_W        = 512,
  parameter int          BEAT_BYTES    = 64,
  parameter int          RING_BEATS    = 4096,
  parameter logic [63:0] BASE_ADDR     = 64'h0,
  parameter int          IN_LOG_DEPTH  = 4,
  parameter int          LEN_LOG_DEPTH = 4,
  parameter int          CTX_LOG_DEPTH = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  dram_ring_loopback_if.slave           bus,
  output logic [$clog2(RING_BEATS):0]   occupancy,
  output logic [31:0]                   cnt_wr,
  output logic [31:0]                   cnt_rd,
  output logic [31:0]                   cnt_jobs,
  output logic [31:0]                   cnt_split
);
  localparam int PW = $clog2(RING_BEATS);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] RING_FULL = OW'(RING_BEATS);
  localparam logic [OW-1:0] LEN_ONE   = 1;
  localparam logic [PW-1:0] PTR_ONE   = 1;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  function automatic logic [63:0] beat_addr(input logic [PW-1:0] p);
    return BASE_ADDR + 64'(p) * 64'(BEAT_BYTES);
  endfunction

  logic              in_push, in_pop, in_empty, in_full_w;
  logic [DATA_W-1:0] in_head_data;
  logic [15:0]       in_head_slot;
  logic [3:0]        in_head_pad;
  logic              in_head_last;
  logic              len_pop, len_empty, len_full;
  logic [OW-1:0]     len_dout;
  logic              side_empty, side_full;
  logic [19:0]       side_dout;
  logic              ctx_empty, ctx_full;
  logic [20:0]       ctx_dout;
  logic [PW-1:0]     wp, rp;
  logic [OW-1:0]     job_len, new_len, rd_left;
  logic              lock_wr, rd_active;
  logic              wr_elig, rd_elig, sel_wr, sel_rd, wr_gnt, rd_gnt;
  logic              job_end, job_split, out_acc;
  rd_state_t         state, state_nxt;

  assign in_push      = bus.in_valid && !in_full_w;
  assign bus.in_full  = in_full_w;

  drl_fifo #(.W(DATA_W + 21), .LOG_D(IN_LOG_DEPTH)) u_in_fifo (
    .clk(clk), .rst(rst), .push(in_push),
    .din({bus.in_data, bus.in_slot, bus.in_pad, bus.in_last}),
    .pop(in_pop), .dout({in_head_data, in_head_slot, in_head_pad, in_head_last}),
    .empty(in_empty), .full(in_full_w)
  );

  drl_fifo #(.W(OW), .LOG_D(LEN_LOG_DEPTH)) u_len_fifo (
    .clk(clk), .rst(rst), .push(job_end), .din(new_len),
    .pop(len_pop), .dout(len_dout), .empty(len_empty), .full(len_full)
  );

  // Slot/pad of every written-but-unread beat; bounded by the ring size.
  drl_fifo #(.W(20), .LOG_D(PW)) u_side_fifo (
    .clk(clk), .rst(rst), .push(wr_gnt), .din({in_head_slot, in_head_pad}),
    .pop(rd_gnt), .dout(side_dout), .empty(side_empty), .full(side_full)
  );

  drl_fifo #(.W(21), .LOG_D(CTX_LOG_DEPTH)) u_ctx_fifo (
    .clk(clk), .rst(rst), .push(rd_gnt), .din({side_dout, rd_left == LEN_ONE}),
    .pop(out_acc), .dout(ctx_dout), .empty(ctx_empty), .full(ctx_full)
  );

  // Arbiter: reads win, except a write already on the bus stays until granted.
  assign wr_elig = !in_empty && (occupancy < RING_FULL) && !len_full && !side_full;
  assign rd_elig = rd_active && !ctx_full && !side_empty;
  assign sel_rd  = rd_elig && !lock_wr;
  assign sel_wr  = wr_elig && !sel_rd;
  assign wr_gnt  = sel_wr && bus.mreq_grant;
  assign rd_gnt  = sel_rd && bus.mreq_grant;
  assign in_pop  = wr_gnt;

  assign bus.mreq_valid    = sel_rd || sel_wr;
  assign bus.mreq_is_write = sel_wr;
  assign bus.mreq_addr     = sel_wr ? beat_addr(wp) : (sel_rd ? beat_addr(rp) : 64'h0);
  assign bus.mreq_data     = sel_wr ? in_head_data : '0;

  assign new_len   = job_len + LEN_ONE;
  assign job_end   = wr_gnt && (in_head_last || new_len == RING_FULL);
  assign job_split = wr_gnt && !in_head_last && new_len == RING_FULL;

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: if (!len_empty) state_nxt = RD_READ;
      RD_READ: if (rd_gnt && rd_left == LEN_ONE) state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    len_pop   = 1'b0;
    rd_active = 1'b0;
    case (state)
      RD_IDLE: len_pop   = !len_empty;
      RD_READ: rd_active = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_valid   = bus.mresp_valid && !ctx_empty;
  assign out_acc         = bus.out_valid && bus.out_grant;
  assign bus.mresp_grant = out_acc;
  assign bus.out_data    = bus.out_valid ? bus.mresp_data : '0;
  assign bus.out_slot    = bus.out_valid ? ctx_dout[20:5] : 16'h0;
  assign bus.out_pad     = bus.out_valid ? ctx_dout[4:1] : 4'h0;
  assign bus.out_last    = bus.out_valid && ctx_dout[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      job_len   <= '0;
      rd_left   <= '0;
      lock_wr   <= 1'b0;
      occupancy <= '0;
      cnt_wr    <= 32'd0;
      cnt_rd    <= 32'd0;
      cnt_jobs  <= 32'd0;
      cnt_split <= 32'd0;
    end else begin
      lock_wr <= sel_wr && !bus.mreq_grant;
      if (wr_gnt) begin
        wp      <= wp + PTR_ONE;
        cnt_wr  <= cnt_wr + 32'd1;
        job_len <= job_end ? '0 : new_len;
      end
      if (rd_gnt) rp <= rp + PTR_ONE;
      if (len_pop)     rd_left <= len_dout;
      else if (rd_gnt) rd_left <= rd_left - LEN_ONE;
      if (job_end)   cnt_jobs  <= cnt_jobs + 32'd1;
      if (job_split) cnt_split <= cnt_split + 32'd1;
      if (out_acc)   cnt_rd    <= cnt_rd + 32'd1;
      case ({wr_gnt, out_acc})
        2'b10:   occupancy <= occupancy + LEN_ONE;
        2'b01:   occupancy <= occupancy - LEN_ONE;
        default: ;
      endcase
    end
  end
endmodule
